// File: rtl/pico_irq_arbiter.sv
// pico_irq_arbiter
//
// Shares the single PicoBlaze interrupt input among up to eight event
// sources. Rising edges on irq_in are latched per source into pending,
// pending sources are granted round-robin, and the grant is held until the
// processor acknowledges it and then writes an end-of-interrupt (EOI).
//
// State | Meaning
// ------+------------------------------------------------------------------
// IDLE  | no grant outstanding; arbitrate over pending & mask
// ASSERT| interrupt driven high, waiting for interrupt_ack
// SERVICE| grant taken by the ISR, waiting for the EOI write
//
// Port map (offsets from BASE_PORT):
//   +0 read : {busy, 4'b0, grant_id[2:0]}
//   +1 read : pending          +1 write : mask <= out_port
//   +2 read : ovf              +2 write : write-1-to-clear ovf
//   +3 write: EOI (data ignored)
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   irq_in        per-source event inputs, synchronous to clk
//   port_id       processor port address
//   write_strobe  processor write qualifier
//   read_strobe   processor read qualifier (reads have no side effects)
//   out_port      processor write data
//   interrupt_ack processor acknowledge pulse
//   interrupt     interrupt request to the processor
//   rd_data       registered read data, 8'h00 when not addressed

module pico_irq_arbiter #(
    parameter int         NUM_SOURCES = 4,
    parameter logic [7:0] BASE_PORT   = 8'h20,
    parameter logic [7:0] MASK_RESET  = 8'hFF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_in,
    input  logic [7:0]             port_id,
    input  logic                   write_strobe,
    input  logic                   read_strobe,
    input  logic [7:0]             out_port,
    input  logic                   interrupt_ack,
    output logic                   interrupt,
    output logic [7:0]             rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [NUM_SOURCES-1:0] SRC_ONE    = NUM_SOURCES'(1);
    localparam logic [NUM_SOURCES-1:0] MASK_INIT  = MASK_RESET[NUM_SOURCES-1:0];
    localparam logic [3:0]             NUM_SRC_W  = 4'(NUM_SOURCES);

    state_t                   state;
    logic [NUM_SOURCES-1:0]   irq_prev;
    logic [NUM_SOURCES-1:0]   pending;
    logic [NUM_SOURCES-1:0]   ovf;
    logic [NUM_SOURCES-1:0]   mask;
    logic [2:0]               rr_ptr;
    logic [2:0]               grant_id;

    // ------------------------------------------------------------------
    // Port decode
    // ------------------------------------------------------------------
    logic addr_hit;
    logic wr_mask;
    logic wr_ovf;
    logic wr_eoi;
    logic eoi_fire;
    logic busy;

    assign addr_hit = (port_id[7:2] == BASE_PORT[7:2]);
    assign wr_mask  = write_strobe && addr_hit && (port_id[1:0] == 2'd1);
    assign wr_ovf   = write_strobe && addr_hit && (port_id[1:0] == 2'd2);
    assign wr_eoi   = write_strobe && addr_hit && (port_id[1:0] == 2'd3);

    // EOI only means something once the ISR owns the grant.
    assign eoi_fire = wr_eoi && (state == ST_SERVICE);
    assign busy     = (state != ST_IDLE);

    // read_strobe carries no behaviour; upper out_port bits are unused
    // when fewer than eight sources are configured.
    logic unused_inputs;
    assign unused_inputs = ^{read_strobe, out_port};

    // ------------------------------------------------------------------
    // Edge detect, pending and overflow next-state
    // ------------------------------------------------------------------
    logic [NUM_SOURCES-1:0] edge_c;
    logic [NUM_SOURCES-1:0] clr_c;
    logic [NUM_SOURCES-1:0] ovf_set_c;
    logic [NUM_SOURCES-1:0] ovf_w1c_c;
    logic [NUM_SOURCES-1:0] pending_nxt;
    logic [NUM_SOURCES-1:0] ovf_nxt;

    assign edge_c      = irq_in & ~irq_prev;
    assign clr_c       = eoi_fire ? (SRC_ONE << grant_id) : '0;
    // An edge that lands on the same cycle as its own EOI simply re-arms
    // the source; it is not a lost event, so no overflow.
    assign ovf_set_c   = edge_c & pending & ~clr_c;
    assign ovf_w1c_c   = wr_ovf ? out_port[NUM_SOURCES-1:0] : '0;
    assign pending_nxt = (pending & ~clr_c) | edge_c;
    assign ovf_nxt     = (ovf & ~ovf_w1c_c) | ovf_set_c;

    // ------------------------------------------------------------------
    // Round-robin pick: rotate eligible down by rr_ptr, take the lowest
    // set bit, then rotate the offset back into a source index.
    // ------------------------------------------------------------------
    logic [NUM_SOURCES-1:0] eligible;
    logic [NUM_SOURCES-1:0] rot_c;
    logic [2:0]             off_c;
    logic [3:0]             sum_c;
    logic                   pick_valid;
    logic [2:0]             pick_id;
    logic [3:0]             rr_next_c;

    assign eligible = pending & mask;
    assign rot_c    = NUM_SOURCES'({eligible, eligible} >> rr_ptr);

    always_comb begin
        pick_valid = 1'b0;
        off_c      = '0;
        for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
            if (rot_c[k]) begin
                pick_valid = 1'b1;
                off_c      = 3'(k);
            end
        end
        sum_c = {1'b0, rr_ptr} + {1'b0, off_c};
        if (sum_c >= NUM_SRC_W) begin
            sum_c = sum_c - NUM_SRC_W;
        end
        pick_id = sum_c[2:0];
    end

    always_comb begin
        rr_next_c = {1'b0, grant_id} + 4'd1;
        if (rr_next_c >= NUM_SRC_W) begin
            rr_next_c = '0;
        end
    end

    // ------------------------------------------------------------------
    // Source bookkeeping registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev <= '0;
            pending  <= '0;
            ovf      <= '0;
            mask     <= MASK_INIT;
        end else begin
            irq_prev <= irq_in;
            pending  <= pending_nxt;
            ovf      <= ovf_nxt;
            if (wr_mask) begin
                mask <= out_port[NUM_SOURCES-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            interrupt <= 1'b0;
            grant_id  <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_id  <= pick_id;
                        interrupt <= 1'b1;
                        state     <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    // mask changes here do not revoke the grant
                    if (interrupt_ack) begin
                        interrupt <= 1'b0;
                        state     <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (wr_eoi) begin
                        rr_ptr <= rr_next_c[2:0];
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    interrupt <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered read port; zero when not addressed so it can be OR-merged
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= 8'h00;
        end else if (addr_hit) begin
            case (port_id[1:0])
                2'd0:    rd_data <= {busy, 4'b0000, grant_id};
                2'd1:    rd_data <= 8'(pending);
                2'd2:    rd_data <= 8'(ovf);
                default: rd_data <= 8'h00;
            endcase
        end else begin
            rd_data <= 8'h00;
        end
    end

endmodule

// File: tb/tb_pico_irq_arbiter.sv
// Directed bench for pico_irq_arbiter (4 sources, base port 8'h20).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so every value checked was registered by the preceding edge.

module tb_pico_irq_arbiter;

    localparam logic [7:0] P_STAT = 8'h20;
    localparam logic [7:0] P_PEND = 8'h21;
    localparam logic [7:0] P_OVF  = 8'h22;
    localparam logic [7:0] P_EOI  = 8'h23;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic       interrupt_ack;
    logic       interrupt;
    logic [7:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] v;

    pico_irq_arbiter #(
        .NUM_SOURCES(4),
        .BASE_PORT  (8'h20),
        .MASK_RESET (8'hFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_in       (irq_in),
        .port_id      (port_id),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .out_port     (out_port),
        .interrupt_ack(interrupt_ack),
        .interrupt    (interrupt),
        .rd_data      (rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input logic exp);
        check(tag, {7'b0, interrupt}, {7'b0, exp});
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] val);
        port_id     = a;
        read_strobe = 1'b1;
        step(1);
        read_strobe = 1'b0;
        port_id     = 8'h00;
        val         = rd_data;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id      = a;
        out_port     = d;
        write_strobe = 1'b1;
        step(1);
        write_strobe = 1'b0;
        port_id      = 8'h00;
        out_port     = 8'h00;
    endtask

    // one cycle high, one cycle low so back-to-back pulses are real edges
    task automatic pulse(input logic [3:0] m);
        irq_in = m;
        step(1);
        irq_in = 4'b0000;
        step(1);
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        step(1);
        interrupt_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic wait_int(input string tag);
        int n = 0;
        while (interrupt !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check_int(tag, 1'b1);
    endtask

    initial begin
        reset         = 1'b1;
        irq_in        = 4'b0000;
        port_id       = 8'h00;
        write_strobe  = 1'b0;
        read_strobe   = 1'b0;
        out_port      = 8'h00;
        interrupt_ack = 1'b0;
        step(2);
        reset = 1'b0;

        // ---- reset state
        check_int("rst_interrupt", 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        rd(P_PEND, v); check("rst_pending", v, 8'h00);
        rd(P_OVF,  v); check("rst_ovf", v, 8'h00);
        rd(P_STAT, v); check("rst_status", v, 8'h00);

        // ---- single source, minimum latency
        irq_in = 4'b0100;
        step(1);
        irq_in = 4'b0000;
        check_int("single_lat1", 1'b0);
        step(1);
        check_int("single_lat2", 1'b1);
        rd(P_STAT, v); check("single_stat_busy", v, 8'h82);
        rd(P_PEND, v); check("single_pending", v, 8'h04);
        ack();
        check_int("single_ack_drop", 1'b0);
        step(2);
        check_int("single_service_low", 1'b0);
        wr(P_EOI, 8'h55);
        rd(P_PEND, v); check("single_pending_clr", v, 8'h00);
        rd(P_STAT, v); check("single_stat_idle", v, 8'h02);

        // ---- round robin from rr_ptr = 0
        do_reset();
        pulse(4'b1011);
        check_int("rr_first_int", 1'b1);
        rd(P_STAT, v); check("rr_grant0", v, 8'h80);
        ack();
        wr(P_EOI, 8'h00);
        wait_int("rr_wait1");
        rd(P_STAT, v); check("rr_grant1", v, 8'h81);
        ack();
        wr(P_EOI, 8'h00);
        wait_int("rr_wait3");
        rd(P_STAT, v); check("rr_grant3", v, 8'h83);
        ack();
        wr(P_EOI, 8'h00);
        rd(P_PEND, v); check("rr_pending_empty", v, 8'h00);

        // grant 0 then both 0 and 1 pending: rr_ptr = 1 so 1 goes first
        pulse(4'b0001);
        check_int("rr2_int", 1'b1);
        ack();
        wr(P_PEND, 8'h00);
        pulse(4'b0010);
        wr(P_EOI, 8'h00);
        pulse(4'b0001);
        check_int("rr2_masked_idle", 1'b0);
        rd(P_PEND, v); check("rr2_pending", v, 8'h03);
        wr(P_PEND, 8'hFF);
        step(1);
        check_int("rr2_unmask_int", 1'b1);
        rd(P_STAT, v); check("rr2_grant1_first", v, 8'h81);
        ack();
        wr(P_EOI, 8'h00);
        wait_int("rr2_wait0");
        rd(P_STAT, v); check("rr2_grant0_second", v, 8'h80);
        ack();
        wr(P_EOI, 8'h00);

        // ---- masking
        wr(P_PEND, 8'hFE);
        pulse(4'b0001);
        check_int("mask_no_int_a", 1'b0);
        step(2);
        check_int("mask_no_int_b", 1'b0);
        rd(P_PEND, v); check("mask_pending", v, 8'h01);
        wr(P_PEND, 8'hFF);
        check_int("mask_unmask_lat1", 1'b0);
        step(1);
        check_int("mask_unmask_lat2", 1'b1);
        rd(P_STAT, v); check("mask_grant0", v, 8'h80);
        ack();
        wr(P_EOI, 8'h00);

        // ---- overflow (rr_ptr = 1)
        pulse(4'b0010);
        check_int("ovf_int", 1'b1);
        rd(P_OVF, v); check("ovf_none", v, 8'h00);
        pulse(4'b0010);
        rd(P_OVF, v); check("ovf_set", v, 8'h02);
        wr(P_OVF, 8'h02);
        rd(P_OVF, v); check("ovf_w1c", v, 8'h00);
        // edge and write-1-to-clear in the same cycle: set wins
        irq_in       = 4'b0010;
        port_id      = P_OVF;
        out_port     = 8'h02;
        write_strobe = 1'b1;
        step(1);
        irq_in       = 4'b0000;
        port_id      = 8'h00;
        out_port     = 8'h00;
        write_strobe = 1'b0;
        rd(P_OVF, v); check("ovf_set_beats_clr", v, 8'h02);
        wr(P_OVF, 8'h0F);
        rd(P_OVF, v); check("ovf_w1c_again", v, 8'h00);
        ack();
        // edge coincident with this source's EOI
        irq_in       = 4'b0010;
        port_id      = P_EOI;
        write_strobe = 1'b1;
        step(1);
        irq_in       = 4'b0000;
        port_id      = 8'h00;
        write_strobe = 1'b0;
        rd(P_PEND, v); check("eoi_edge_pending", v, 8'h02);
        rd(P_OVF, v);  check("eoi_edge_no_ovf", v, 8'h00);
        rd(P_STAT, v); check("eoi_edge_regrant", v, 8'h81);
        check_int("eoi_edge_int", 1'b1);
        ack();
        wr(P_EOI, 8'h00);

        // ---- protocol errors (rr_ptr = 2)
        ack();
        check_int("stray_ack_int", 1'b0);
        rd(P_STAT, v); check("stray_ack_stat", v, 8'h01);
        pulse(4'b0100);
        check_int("proto_int", 1'b1);
        wr(P_EOI, 8'h00);
        check_int("eoi_in_assert_int", 1'b1);
        rd(P_STAT, v); check("eoi_in_assert_stat", v, 8'h82);
        rd(P_PEND, v); check("eoi_in_assert_pend", v, 8'h04);
        rd(8'h24, v);  check("unmapped_24", v, 8'h00);
        rd(8'h1F, v);  check("unmapped_1f", v, 8'h00);
        ack();
        wr(P_EOI, 8'h00);

        // ---- reset in SERVICE with three pending (rr_ptr = 3)
        pulse(4'b0111);
        check_int("rstsvc_int", 1'b1);
        rd(P_STAT, v); check("rstsvc_grant0", v, 8'h80);
        ack();
        do_reset();
        check_int("rstsvc_int_low", 1'b0);
        rd(P_PEND, v); check("rstsvc_pending", v, 8'h00);
        rd(P_STAT, v); check("rstsvc_stat", v, 8'h00);
        rd(P_OVF, v);  check("rstsvc_ovf", v, 8'h00);
        step(3);
        check_int("rstsvc_no_grant", 1'b0);
        pulse(4'b1000);
        check_int("rstsvc_mask_ff", 1'b1);
        rd(P_STAT, v); check("rstsvc_grant3", v, 8'h83);
        do_reset();
        check_int("rst_in_assert", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
